// File: rtl/gbr_pkg.sv
// Shared constants for the genetic route search: family geometry, cost width and FSM encoding.
// The mutation stage imports the same constants so the family bus layout always matches.
package gbr_pkg;

  localparam int unsigned MEMBERS  = 5;
  localparam int unsigned GENES    = 30;
  localparam int unsigned GENE_W   = 5;
  localparam int unsigned COST_W   = 10;

  localparam int unsigned CHROM_W  = GENES * GENE_W;
  localparam int unsigned FAMILY_W = MEMBERS * CHROM_W;
  localparam int unsigned IDX_W    = $clog2(MEMBERS);
  localparam int unsigned PAIR_W   = $clog2(GENES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [GENE_W-1:0] abs_diff(input logic [GENE_W-1:0] a,
                                                 input logic [GENE_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pair_cost.sv
// Combinational distance between two adjacent genes (unsigned absolute difference).
module pair_cost
  import gbr_pkg::*;
#(
  parameter int unsigned GENE_W = gbr_pkg::GENE_W
) (
  input  logic [GENE_W-1:0] i_a,
  input  logic [GENE_W-1:0] i_b,
  output logic [GENE_W-1:0] o_diff
);

  always_comb begin
    o_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
  end

endmodule

// File: rtl/family_selector.sv
// Scores every member of a snapshotted family one gene pair per cycle and returns the
// lowest-cost chromosome (ties to the lowest index) with a single-cycle done pulse.
module family_selector
  import gbr_pkg::*;
#(
  parameter int unsigned MEMBERS = gbr_pkg::MEMBERS,
  parameter int unsigned GENES   = gbr_pkg::GENES,
  parameter int unsigned GENE_W  = gbr_pkg::GENE_W,
  parameter int unsigned COST_W  = gbr_pkg::COST_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [MEMBERS*GENES*GENE_W-1:0]     family,
  output logic [GENES*GENE_W-1:0]             best,
  output logic [COST_W-1:0]                   best_cost,
  output logic [$clog2(MEMBERS)-1:0]          best_index,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned CH_W  = GENES * GENE_W;
  localparam int unsigned FAM_W = MEMBERS * CH_W;
  localparam int unsigned M_W   = $clog2(MEMBERS);
  localparam int unsigned K_W   = $clog2(GENES - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(GENES - 2);
  localparam logic [M_W-1:0] M_LAST = M_W'(MEMBERS - 1);

  logic [1:0]        r_state;
  logic [FAM_W-1:0]  r_snap;
  logic [M_W-1:0]    r_m;
  logic [K_W-1:0]    r_k;
  logic [COST_W-1:0] r_acc;
  logic [CH_W-1:0]   r_rb_chrom;
  logic [COST_W-1:0] r_rb_cost;
  logic [M_W-1:0]    r_rb_idx;
  logic [CH_W-1:0]   r_best;
  logic [COST_W-1:0] r_best_cost;
  logic [M_W-1:0]    r_best_idx;
  logic              r_done;

  logic [CH_W-1:0]   w_member;
  logic [GENE_W-1:0] w_ga;
  logic [GENE_W-1:0] w_gb;
  logic [GENE_W-1:0] w_diff;
  logic [COST_W-1:0] w_cost;
  logic              w_last_pair;
  logic              w_last_member;
  logic              w_take;
  logic              w_accept;
  logic [CH_W-1:0]   w_nb_chrom;
  logic [COST_W-1:0] w_nb_cost;
  logic [M_W-1:0]    w_nb_idx;

  // Gene mux: member m, genes k and k+1 of the snapshot.
  always_comb begin
    w_member = r_snap[r_m*CH_W +: CH_W];
    w_ga     = w_member[r_k*GENE_W +: GENE_W];
    w_gb     = w_member[(r_k+1)*GENE_W +: GENE_W];
  end

  pair_cost #(
    .GENE_W(GENE_W)
  ) u_pair_cost (
    .i_a   (w_ga),
    .i_b   (w_gb),
    .o_diff(w_diff)
  );

  // Next running-best is formed combinationally so the final member can be
  // compared and published to the outputs on the same EVAL->DONE edge.
  always_comb begin
    w_cost        = r_acc + COST_W'(w_diff);
    w_last_pair   = (r_k == K_LAST);
    w_last_member = (r_m == M_LAST);
    w_take        = w_last_pair && ((r_m == '0) || (w_cost < r_rb_cost));
    w_nb_chrom    = w_take ? w_member : r_rb_chrom;
    w_nb_cost     = w_take ? w_cost   : r_rb_cost;
    w_nb_idx      = w_take ? r_m      : r_rb_idx;
  end

  // Leaving DONE with start high is treated as the IDLE accept of that same
  // edge, which keeps back-to-back runs at a 146-cycle period.
  always_comb begin
    w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_m     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_EVAL;
            r_snap  <= family;
            r_m     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          if (w_last_pair) begin
            r_acc <= '0;
            r_k   <= '0;
            r_m   <= r_m + M_W'(1);
            if (w_last_member) begin
              r_state <= ST_DONE;
            end
          end else begin
            r_acc <= w_cost;
            r_k   <= r_k + K_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_chrom <= '0;
      r_rb_cost  <= '0;
      r_rb_idx   <= '0;
    end else if (r_state == ST_EVAL) begin
      r_rb_chrom <= w_nb_chrom;
      r_rb_cost  <= w_nb_cost;
      r_rb_idx   <= w_nb_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best      <= '0;
      r_best_cost <= '0;
      r_best_idx  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == ST_EVAL) && w_last_pair && w_last_member) begin
        r_best      <= w_nb_chrom;
        r_best_cost <= w_nb_cost;
        r_best_idx  <= w_nb_idx;
        r_done      <= 1'b1;
      end
    end
  end

  always_comb begin
    best       = r_best;
    best_cost  = r_best_cost;
    best_index = r_best_idx;
    busy       = (r_state != ST_IDLE);
    done       = r_done;
  end

endmodule

// File: tb/tb_family_selector.sv
// Directed, table-driven bench for family_selector with hand-computed member costs.
module tb_family_selector;
  import gbr_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [FAMILY_W-1:0]   family;
  logic [CHROM_W-1:0]    best;
  logic [COST_W-1:0]     best_cost;
  logic [IDX_W-1:0]      best_index;
  logic                  busy;
  logic                  done;

  family_selector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .family    (family),
    .best      (best),
    .best_cost (best_cost),
    .best_index(best_index),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FAMILY_W-1:0] fam;
    logic [COST_W-1:0]   cost;
    logic [IDX_W-1:0]    idx;
    logic [CHROM_W-1:0]  bst;
  } vec_t;

  vec_t vecs[6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [FAMILY_W-1:0] got,
                     input logic [FAMILY_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // kind 0: all p (cost 0); 1: 0..29 (cost 29); 2: 29..0 (cost 29);
  // 3: alternating 0/31 (cost 899); 4: alternating 0/1 (cost 29);
  // 5: all p except gene 10 = p+1 (cost 2)
  function automatic logic [CHROM_W-1:0] chrom(input int kind, input int p);
    logic [CHROM_W-1:0] c;
    c = '0;
    for (int g = 0; g < int'(GENES); g++) begin
      int v;
      case (kind)
        0:       v = p;
        1:       v = g;
        2:       v = 29 - g;
        3:       v = (g % 2) ? 31 : 0;
        4:       v = g % 2;
        default: v = (g == 10) ? p + 1 : p;
      endcase
      c[g*GENE_W +: GENE_W] = GENE_W'(v);
    end
    return c;
  endfunction

  function automatic logic [FAMILY_W-1:0] fam5(input logic [CHROM_W-1:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, wait for done, check latency, result and the pulse shape.
  task automatic run_vec(input int vi, input string nm);
    int cyc;
    family = vecs[vi].fam;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    cyc    = 0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, FAMILY_W'(cyc), FAMILY_W'(145));
    chk({nm, "_cost"},    FAMILY_W'(best_cost), FAMILY_W'(vecs[vi].cost));
    chk({nm, "_index"},   FAMILY_W'(best_index), FAMILY_W'(vecs[vi].idx));
    chk({nm, "_best"},    FAMILY_W'(best), FAMILY_W'(vecs[vi].bst));
    chk({nm, "_busy_in_done"}, FAMILY_W'(busy), FAMILY_W'(1));
    tick();
    chk({nm, "_done_fall"}, FAMILY_W'(done), FAMILY_W'(0));
    chk({nm, "_busy_fall"}, FAMILY_W'(busy), FAMILY_W'(0));
    chk({nm, "_hold_cost"}, FAMILY_W'(best_cost), FAMILY_W'(vecs[vi].cost));
  endtask

  initial begin
    int cyc;
    int ndone;
    int t_done[3];
    logic [COST_W-1:0] sc_cost;
    logic [IDX_W-1:0]  sc_idx;

    vecs[0] = '{fam: '0, cost: 10'd0, idx: 3'd0, bst: '0};
    vecs[1] = '{fam: fam5(chrom(1,0), chrom(3,0), chrom(3,0), chrom(0,7), chrom(3,0)),
                cost: 10'd0, idx: 3'd3, bst: chrom(0,7)};
    vecs[2] = '{fam: fam5(chrom(1,0), chrom(3,0), chrom(2,0), chrom(3,0), chrom(3,0)),
                cost: 10'd29, idx: 3'd0, bst: chrom(1,0)};
    vecs[3] = '{fam: fam5(chrom(3,0), chrom(3,0), chrom(4,0), chrom(2,0), chrom(5,5)),
                cost: 10'd2, idx: 3'd4, bst: chrom(5,5)};
    vecs[4] = '{fam: fam5(chrom(3,0), chrom(3,0), chrom(3,0), chrom(3,0), chrom(3,0)),
                cost: 10'd899, idx: 3'd0, bst: chrom(3,0)};
    vecs[5] = '{fam: fam5(chrom(3,0), chrom(1,0), chrom(2,0), chrom(4,0), chrom(1,0)),
                cost: 10'd29, idx: 3'd1, bst: chrom(1,0)};

    rst_n  = 1'b0;
    start  = 1'b0;
    family = '0;
    #22;
    chk("rst_busy",  FAMILY_W'(busy), FAMILY_W'(0));
    chk("rst_done",  FAMILY_W'(done), FAMILY_W'(0));
    chk("rst_cost",  FAMILY_W'(best_cost), FAMILY_W'(0));
    chk("rst_index", FAMILY_W'(best_index), FAMILY_W'(0));
    chk("rst_best",  FAMILY_W'(best), FAMILY_W'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(i, $sformatf("vec%0d", i));
      tick();
    end

    // Scribble family and pulse start throughout EVAL; the snapshot must win.
    family = vecs[2].fam;
    start  = 1'b1;
    tick();
    ndone   = 0;
    sc_cost = '1;
    sc_idx  = '1;
    for (int c = 1; c <= 400; c++) begin
      if (c < 140) begin
        for (int g = 0; g < int'(MEMBERS*GENES); g++)
          family[g*GENE_W +: GENE_W] = GENE_W'($urandom_range(0, 31));
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        sc_cost = best_cost;
        sc_idx  = best_index;
      end
    end
    chk("scribble_ndone", FAMILY_W'(ndone), FAMILY_W'(1));
    chk("scribble_cost",  FAMILY_W'(sc_cost), FAMILY_W'(29));
    chk("scribble_index", FAMILY_W'(sc_idx), FAMILY_W'(0));
    chk("scribble_best",  FAMILY_W'(best), FAMILY_W'(vecs[2].bst));

    // Abort at cycle 60 of EVAL; the previous run left nonzero outputs.
    run_vec(3, "pre_abort");
    family = vecs[4].fam;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 0; c < 60; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_cost",  FAMILY_W'(best_cost), FAMILY_W'(0));
    chk("abort_index", FAMILY_W'(best_index), FAMILY_W'(0));
    chk("abort_best",  FAMILY_W'(best), FAMILY_W'(0));
    chk("abort_busy",  FAMILY_W'(busy), FAMILY_W'(0));
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", FAMILY_W'(ndone), FAMILY_W'(0));
    run_vec(1, "post_abort");
    tick();

    // start held high: done every 146 cycles with identical results.
    family = vecs[3].fam;
    start  = 1'b1;
    tick();
    cyc   = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 600) begin
      tick();
      cyc++;
      if (done) begin
        t_done[ndone] = cyc;
        chk($sformatf("held%0d_cost", ndone),  FAMILY_W'(best_cost), FAMILY_W'(2));
        chk($sformatf("held%0d_index", ndone), FAMILY_W'(best_index), FAMILY_W'(4));
        ndone++;
      end
    end
    start = 1'b0;
    chk("held_ndone", FAMILY_W'(ndone), FAMILY_W'(3));
    if (ndone == 3) begin
      chk("held_first",   FAMILY_W'(t_done[0]), FAMILY_W'(145));
      chk("held_period1", FAMILY_W'(t_done[1] - t_done[0]), FAMILY_W'(146));
      chk("held_period2", FAMILY_W'(t_done[2] - t_done[1]), FAMILY_W'(146));
    end
    tick();
    tick();
    chk("held_idle", FAMILY_W'(busy), FAMILY_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
